// File: rtl/resample_mixer_pkg.sv
// resample_pkg: shared types, constants and helpers for the resample_mixer
// speed-change engine.
package resample_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_ACC,
        S_WR,
        S_ADV,
        S_DONE
    } state_t;

    // round(32768 / r) for r = 1..16; entry 0 is never used.
    localparam logic [16:0][16:0] RECIP_TBL = {
        17'd2048,  17'd2185,  17'd2341,  17'd2521,
        17'd2731,  17'd2979,  17'd3277,  17'd3641,
        17'd4096,  17'd4681,  17'd5461,  17'd6554,
        17'd8192,  17'd10923, 17'd16384, 17'd32768,
        17'd0
    };

    // Clamp a wide signed sum into the 16-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/resample_mixer_if.sv
// resample_mixer_if: single-word SDRAM read/write/finished port.
// master = engine side, slave = arbiter/memory side.
interface resample_mixer_if #(
    parameter int ADDR_W = 23
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_finished;

    modport master (
        output mem_read, mem_write, mem_addr, mem_writedata,
        input  mem_readdata, mem_finished
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_writedata,
        output mem_readdata, mem_finished
    );
endinterface

// File: rtl/resample_mixer_interp.sv
// resample_interp: linear interpolator between x0 and x1 at phase k/r,
// y = x0 + (((x1-x0)*k*RECIP[r]) >>> 15), registered with one cycle of latency.
// Only built when RESAMPLE_INTERP_EN is defined.
`ifdef RESAMPLE_INTERP_EN
module resample_interp
    import resample_pkg::*;
#(
    parameter int SPEED_W = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_vld,
    input  logic signed [SAMPLE_W-1:0] i_x0,
    input  logic signed [SAMPLE_W-1:0] i_x1,
    input  logic [SPEED_W-1:0]         i_k,
    input  logic [SPEED_W:0]           i_r,
    output logic                       o_vld,
    output logic signed [SAMPLE_W-1:0] o_y
);
    logic signed [SAMPLE_W:0] w_diff;
    logic [21:0]              w_scale;
    logic signed [47:0]       w_prod;
    logic signed [47:0]       w_y_full;
    logic                     w_unused_hi;

    // k < r keeps k*RECIP[r] below 32768, so y always lies between x0 and x1
    // and the low 16 bits of the sum are the exact result.
    assign w_diff      = (SAMPLE_W+1)'(i_x1) - (SAMPLE_W+1)'(i_x0);
    assign w_scale     = 22'(i_k) * 22'(RECIP_TBL[i_r]);
    assign w_prod      = 48'(w_diff) * $signed({26'd0, w_scale});
    assign w_y_full    = 48'(i_x0) + (w_prod >>> 15);
    assign w_unused_hi = ^w_y_full[47:SAMPLE_W];

    // Result-valid flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_vld <= 1'b0;
        else
            o_vld <= i_vld;
    end

    // Result register, loaded when the x1 read completes
    always_ff @(posedge i_clk) begin
        if (i_vld)
            o_y <= w_y_full[SAMPLE_W-1:0];
    end
endmodule
`endif

// File: rtl/resample_mixer.sv
// resample_mixer: reads NCH source tracks, applies an integer fast (skip) or
// slow (repeat) ratio, sums the tracks with saturation and writes the mixed
// stream back through a single-word memory port.
// Optional: define RESAMPLE_INTERP_EN to interpolate between x0 and x1 in slow mode.
module resample_mixer
    import resample_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 23,
    parameter int LEN_W   = 20,
    parameter int SPEED_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NCH*ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0]     i_dst_addr,
    input  logic [LEN_W-1:0]      i_length,
    input  logic                  i_mode,
    input  logic [SPEED_W-1:0]    i_speed,
    output logic                  o_busy,
    output logic                  o_done,
    resample_mixer_if.master      mem
);
    localparam int ACC_W = SAMPLE_W + $clog2(NCH);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t                      r_state, w_next;
    logic [ADDR_W-1:0]           r_src [NCH];
    logic [ADDR_W-1:0]           r_dst;
    logic [LEN_W-1:0]            r_len;
    logic                        r_mode;
    logic [SPEED_W:0]            r_r;
    logic [CH_W-1:0]             r_c;
    logic [LEN_W-1:0]            r_i;
    logic [ADDR_W-1:0]           r_p;
    logic [SPEED_W-1:0]          r_k;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [SAMPLE_W-1:0]  r_x0;

    logic                        w_accept;
    logic                        w_last_ch;
    logic                        w_last_out;
    logic                        w_need_x1;
    logic signed [SAMPLE_W-1:0]  w_sample;
    logic                        w_sample_vld;
    logic signed [SAMPLE_W-1:0]  w_sat;
    logic                        w_unused;

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_last_ch  = (r_c == CH_W'(NCH - 1));
    assign w_last_out = (r_i == r_len - LEN_W'(1));
    assign w_sat      = sat16(32'(r_acc));
    assign w_unused   = ^mem.mem_readdata[31:SAMPLE_W];

`ifdef RESAMPLE_INTERP_EN
    logic                       w_interp_go;
    logic                       w_interp_vld;
    logic signed [SAMPLE_W-1:0] w_x1;
    logic signed [SAMPLE_W-1:0] w_interp_y;

    assign w_need_x1   = r_mode && (r_k != '0);
    assign w_interp_go = (r_state == S_RD1) && mem.mem_finished;
    assign w_x1        = mem.mem_readdata[SAMPLE_W-1:0];

    resample_interp #(.SPEED_W(SPEED_W)) u_interp (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_vld (w_interp_go),
        .i_x0  (r_x0),
        .i_x1  (w_x1),
        .i_k   (r_k),
        .i_r   (r_r),
        .o_vld (w_interp_vld),
        .o_y   (w_interp_y)
    );

    assign w_sample     = w_need_x1 ? w_interp_y : r_x0;
    assign w_sample_vld = !w_need_x1 || w_interp_vld;
`else
    assign w_need_x1    = 1'b0;
    assign w_sample     = r_x0;
    assign w_sample_vld = 1'b1;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Loop counters: track index, output index, shared pointer and slow-mode phase
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c <= '0;
            r_i <= '0;
            r_p <= '0;
            r_k <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_c <= '0;
                        r_i <= '0;
                        r_p <= '0;
                        r_k <= '0;
                    end
                end
                S_ACC: begin
                    if (w_sample_vld)
                        r_c <= w_last_ch ? '0 : r_c + CH_W'(1);
                end
                S_ADV: begin
                    r_i <= r_i + LEN_W'(1);
                    if (!r_mode) begin
                        r_p <= r_p + ADDR_W'(r_r);
                    end else if ({1'b0, r_k} == r_r - (SPEED_W+1)'(1)) begin
                        r_k <= '0;
                        r_p <= r_p + ADDR_W'(1);
                    end else begin
                        r_k <= r_k + SPEED_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Job configuration latch and sample/accumulator datapath
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int c = 0; c < NCH; c++)
                r_src[c] <= i_src_addr[c*ADDR_W +: ADDR_W];
            r_dst  <= i_dst_addr;
            r_len  <= i_length;
            r_mode <= i_mode;
            r_r    <= {1'b0, i_speed} + (SPEED_W+1)'(1);
            r_acc  <= '0;
        end
        if ((r_state == S_RD0) && mem.mem_finished)
            r_x0 <= mem.mem_readdata[SAMPLE_W-1:0];
        if ((r_state == S_ACC) && w_sample_vld)
            r_acc <= r_acc + ACC_W'(w_sample);
        if (r_state == S_ADV)
            r_acc <= '0;
    end

    // Next-state logic and memory/status outputs
    always_comb begin
        w_next            = r_state;
        mem.mem_read      = 1'b0;
        mem.mem_write     = 1'b0;
        mem.mem_addr      = '0;
        mem.mem_writedata = '0;
        o_busy            = 1'b1;
        o_done            = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start)
                    w_next = (i_length == '0) ? S_DONE : S_RD0;
            end
            S_RD0: begin
                mem.mem_read = 1'b1;
                mem.mem_addr = r_src[r_c] + r_p;
                if (mem.mem_finished)
                    w_next = w_need_x1 ? S_RD1 : S_ACC;
            end
            S_RD1: begin
                mem.mem_read = 1'b1;
                mem.mem_addr = r_src[r_c] + r_p + ADDR_W'(1);
                if (mem.mem_finished)
                    w_next = S_ACC;
            end
            S_ACC: begin
                if (w_sample_vld)
                    w_next = w_last_ch ? S_WR : S_RD0;
            end
            S_WR: begin
                mem.mem_write     = 1'b1;
                mem.mem_addr      = r_dst + ADDR_W'(r_i);
                mem.mem_writedata = 32'(w_sat);
                if (mem.mem_finished)
                    w_next = S_ADV;
            end
            S_ADV: begin
                w_next = w_last_out ? S_DONE : S_RD0;
            end
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_resample_mixer.sv
// tb_resample_mixer: scoreboard bench for resample_mixer. A reference model
// computes every expected read address and written sample from the job
// parameters; a memory responder answers requests and a monitor compares.
`timescale 1ns/1ps
module tb_resample_mixer;
    localparam int NCH     = 2;
    localparam int ADDR_W  = 23;
    localparam int LEN_W   = 20;
    localparam int SPEED_W = 4;
    localparam int RD_DLY  = 3;
    localparam int WR_DLY  = 2;
    localparam int AMASK   = (1 << ADDR_W) - 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NCH*ADDR_W-1:0] src;
    logic [ADDR_W-1:0]     dst;
    logic [LEN_W-1:0]      len;
    logic                  mode;
    logic [SPEED_W-1:0]    speed;
    logic                  busy;
    logic                  done;

    int checks     = 0;
    int errors     = 0;
    int rd_seen    = 0;
    int done_seen  = 0;
    int req_cycles = 0;

    logic [15:0] smem [int];
    int          exp_rd [$];
    wr_t         exp_wr [$];

    always #5 clk = ~clk;

    resample_mixer_if #(.ADDR_W(ADDR_W)) bus ();

    resample_mixer #(
        .NCH(NCH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SPEED_W(SPEED_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_src_addr (src),
        .i_dst_addr (dst),
        .i_length   (len),
        .i_mode     (mode),
        .i_speed    (speed),
        .o_busy     (busy),
        .o_done     (done),
        .mem        (bus)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input longint act, input longint exp);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] memval(input int a);
        if (smem.exists(a))
            return smem[a];
        return 16'(a) ^ 16'h5A5A;
    endfunction

    // Reference model: output i of a job uses pointer p and phase k derived
    // directly from the ratio, reads every track, mixes and saturates.
    task automatic push_job(input int s0, input int s1, input int d, input int n,
                            input bit m, input int sp);
        int r;
        int sv [2];
        r = sp + 1;
        sv[0] = s0;
        sv[1] = s1;
        for (int i = 0; i < n; i++) begin
            int     p;
            int     k;
            longint sum;
            p   = m ? (i / r) : (i * r);
            k   = m ? (i % r) : 0;
            sum = 0;
            for (int c = 0; c < NCH; c++) begin
                int     a0;
                longint x0;
                longint y;
                a0 = (sv[c] + p) & AMASK;
                exp_rd.push_back(a0);
                x0 = longint'($signed(memval(a0)));
                y  = x0;
`ifdef RESAMPLE_INTERP_EN
                if (m && k != 0) begin
                    int     a1;
                    longint x1;
                    longint rc;
                    a1 = (sv[c] + p + 1) & AMASK;
                    exp_rd.push_back(a1);
                    x1 = longint'($signed(memval(a1)));
                    rc = (32768 + r / 2) / r;
                    y  = x0 + (((x1 - x0) * k * rc) >>> 15);
                end
`endif
                sum += y;
            end
            if (sum > 32767)  sum = 32767;
            if (sum < -32768) sum = -32768;
            exp_wr.push_back('{(d + i) & AMASK, 32'(sum)});
        end
    endtask

    task automatic fill(input int base, input int n);
        for (int j = 0; j < n; j++) begin
            int v;
            if ($urandom_range(0, 3) == 0)
                v = ($urandom_range(0, 1) == 1 ? 1 : -1) * int'($urandom_range(28000, 32767));
            else
                v = int'($urandom_range(0, 65535)) - 32768;
            smem[(base + j) & AMASK] = 16'(v);
        end
    endtask

    task automatic drive_start(input int s0, input int s1, input int d, input int n,
                               input bit m, input int sp);
        src   = {ADDR_W'(s1), ADDR_W'(s0)};
        dst   = ADDR_W'(d);
        len   = LEN_W'(n);
        mode  = m;
        speed = SPEED_W'(sp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(input int s0, input int s1, input int d, input int n,
                           input bit m, input int sp, input bit poke);
        int d0;
        bit got;
        d0  = done_seen;
        got = 1'b0;
        push_job(s0, s1, d, n, m, sp);
        drive_start(s0, s1, d, n, m, sp);
        check("busy_after_start", busy, 1);
        if (poke) begin
            repeat (3) @(negedge clk);
            check("busy_before_poke", busy, 1);
            drive_start(int'($urandom), int'($urandom), int'($urandom), 1, ~m, 15 - sp);
        end
        for (int t = 0; t < 4000 && !got; t++) begin
            @(negedge clk);
            if (done_seen != d0) got = 1'b1;
        end
        if (!got) note_fail("done_timeout", done_seen - d0, 1);
        repeat (3) @(negedge clk);
        check("done_pulses", done_seen - d0, 1);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
    endtask

    // Memory responder: finished after RD_DLY/WR_DLY cycles of a held request
    initial begin
        int dly;
        dly = 0;
        bus.mem_finished = 1'b0;
        bus.mem_readdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.mem_finished) begin
                bus.mem_finished = 1'b0;
            end else if (rst || !(bus.mem_read || bus.mem_write)) begin
                dly = 0;
            end else begin
                dly++;
                if (dly >= (bus.mem_read ? RD_DLY : WR_DLY)) begin
                    dly = 0;
                    bus.mem_finished = 1'b1;
                    bus.mem_readdata = {16'($urandom), memval(int'(bus.mem_addr))};
                end
            end
        end
    end

    // Monitor: compares every completed read/write against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_read || bus.mem_write) req_cycles++;
                if (bus.mem_read && bus.mem_write)
                    note_fail("rd_wr_together", 1, 0);
                if (bus.mem_read && bus.mem_finished) begin
                    rd_seen++;
                    if (exp_rd.size() == 0)
                        note_fail("rd_unexpected", int'(bus.mem_addr), -1);
                    else
                        check("rd_addr", int'(bus.mem_addr), exp_rd.pop_front());
                end
                if (bus.mem_write && bus.mem_finished) begin
                    if (exp_wr.size() == 0) begin
                        note_fail("wr_unexpected", bus.mem_writedata, -1);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        check("wr_addr", int'(bus.mem_addr), e.addr);
                        check("wr_data", bus.mem_writedata, e.data);
                    end
                end
                if (done) begin
                    done_seen++;
                    check("busy_low_at_done", busy, 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
        $fatal(1);
    end

    initial begin
        int r0;
        int a0;
        int d0;
        int lat;
        bit got;

        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; mode = 1'b0; speed = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",  busy, 0);
        check("reset_done",  done, 0);
        check("reset_read",  bus.mem_read, 0);
        check("reset_write", bus.mem_write, 0);
        check("reset_addr",  bus.mem_addr, 0);
        check("reset_wdata", bus.mem_writedata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic mix: 100 + 200 over four outputs at ratio 1
        for (int j = 0; j < 8; j++) begin
            smem[1000 + j] = 16'd100;
            smem[2000 + j] = 16'd200;
        end
        r0 = rd_seen;
        run_job(1000, 2000, 5000, 4, 1'b0, 0, 1'b0);
        check("t1_read_count", rd_seen - r0, 8);

        // Fast mode ratio 3 from address 0
        fill(0, 16);
        fill(3000, 16);
        run_job(0, 3000, 6000, 3, 1'b0, 2, 1'b0);

        // Saturation both ways
        smem[7000] = 16'd30000;
        smem[7100] = 16'd30000;
        run_job(7000, 7100, 7500, 1, 1'b0, 0, 1'b0);
        smem[7200] = 16'(-30000);
        smem[7300] = 16'(-30000);
        run_job(7200, 7300, 7600, 1, 1'b0, 0, 1'b0);

        // Slow mode ratio 2: repeat, or interpolate when enabled
        smem[8000] = 16'd0;   smem[8001] = 16'd100;
        smem[8002] = 16'd300; smem[8003] = 16'd0;
        for (int j = 0; j < 4; j++) smem[8100 + j] = 16'd0;
        run_job(8000, 8100, 8500, 4, 1'b1, 1, 1'b0);

        // Zero length: done without any memory traffic
        a0 = req_cycles;
        d0 = done_seen;
        drive_start(9000, 9100, 9500, 0, 1'b0, 0);
        lat = 1;
        while (!done && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        check("len0_done_latency", (done && lat <= 2), 1);
        repeat (3) @(negedge clk);
        check("len0_no_mem", req_cycles - a0, 0);
        check("len0_done_pulses", done_seen - d0, 1);

        // Start while busy is ignored
        fill(9200, 40);
        fill(9300, 40);
        run_job(9200, 9300, 9600, 6, 1'b0, 1, 1'b1);

        // Reset during a held read
        push_job(1000, 2000, 5000, 4, 1'b0, 0);
        drive_start(1000, 2000, 5000, 4, 1'b0, 0);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            if (bus.mem_read) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) note_fail("rst_wait_read", 0, 1);
        @(negedge clk);
        check("rst_read_held", bus.mem_read, 1);
        rst = 1'b1;
        #1;
        check("rst_read",  bus.mem_read, 0);
        check("rst_write", bus.mem_write, 0);
        check("rst_addr",  bus.mem_addr, 0);
        check("rst_wdata", bus.mem_writedata, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        exp_rd.delete();
        exp_wr.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r0 = rd_seen;
        run_job(1000, 2000, 5000, 4, 1'b0, 0, 1'b0);
        check("rst_t1_read_count", rd_seen - r0, 8);

        // Randomized jobs, including address wrap at the top of memory
        for (int j = 0; j < 10; j++) begin
            int s0;
            int s1;
            int d;
            s0 = (j == 0) ? 32'h7FFFF8 : int'($urandom_range(0, AMASK));
            s1 = int'($urandom_range(0, AMASK));
            d  = (j == 1) ? 32'h7FFFFC : 32'h400000 + j * 64;
            fill(s0, 200);
            fill(s1, 200);
            run_job(s0, s1, d, int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
